sum_window_checker: RTL and testbench

SUM_WINDOW_CHECKER -- requirements
Module: sum_window_checker

---
 rtl/sum_window_checker.sv | 150 +++++++++++++++
 tb/tb_sum_window_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_window_checker.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_checker
// Brief    : Accumulates a window of upstream sum samples. For each window it
//            reports the total, the maximum, the bad-sample count and the
//            sample count over a valid/ready handshake. A flush request
//            reports a partial window early.
// Options  : SUM_WINDOW_CHECKER_STICKY_EN - when defined, err_sticky latches
//            any accepted bad sample until reset. When undefined, err_sticky
//            is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sum_window_checker #(
  parameter int WINDOW = 4              // samples per report, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_sum,
  input  logic        in_bad,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_total,
  output logic [8:0]  out_max,
  output logic [3:0]  out_bad_cnt,
  output logic [3:0]  out_count,
  output logic        err_sticky
);

  localparam logic [3:0] WIN_CNT = 4'(WINDOW);

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [12:0] acc_total;
  logic [8:0]  acc_max;
  logic [3:0]  acc_bad;
  logic [3:0]  acc_cnt;

  logic        accept;
  logic        load;
  logic [12:0] total_upd;
  logic [8:0]  max_upd;
  logic [3:0]  bad_upd;
  logic [3:0]  cnt_upd;

  // Accumulator values including this cycle's sample, plus the report-load decision
  always_comb begin
    accept    = in_valid && (state == ST_ACCUM);
    total_upd = acc_total;
    max_upd   = acc_max;
    bad_upd   = acc_bad;
    cnt_upd   = acc_cnt;
    if (accept) begin
      // 15 * 511 fits in 13 bits, so the total cannot overflow
      total_upd = acc_total + {4'd0, in_sum};
      if (in_sum > acc_max) begin
        max_upd = in_sum;
      end
      bad_upd   = acc_bad + {3'd0, in_bad};
      cnt_upd   = acc_cnt + 4'd1;
    end
    // A flush only reports when the window (including a same-cycle sample) is non-empty
    load = (state == ST_ACCUM) &&
           ((accept && (cnt_upd == WIN_CNT)) || (flush && (cnt_upd != 4'd0)));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (load) begin
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_ACCUM;
        end
      end
      default: begin
        state_nxt = ST_ACCUM;
      end
    endcase
  end

  // Accumulators and report registers; reports persist until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_total   <= 13'd0;
      acc_max     <= 9'd0;
      acc_bad     <= 4'd0;
      acc_cnt     <= 4'd0;
      out_total   <= 13'd0;
      out_max     <= 9'd0;
      out_bad_cnt <= 4'd0;
      out_count   <= 4'd0;
    end else if (load) begin
      out_total   <= total_upd;
      out_max     <= max_upd;
      out_bad_cnt <= bad_upd;
      out_count   <= cnt_upd;
      acc_total   <= 13'd0;
      acc_max     <= 9'd0;
      acc_bad     <= 4'd0;
      acc_cnt     <= 4'd0;
    end else if (accept) begin
      acc_total   <= total_upd;
      acc_max     <= max_upd;
      acc_bad     <= bad_upd;
      acc_cnt     <= cnt_upd;
    end
  end

`ifdef SUM_WINDOW_CHECKER_STICKY_EN
  // Latch any accepted bad sample until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (accept && in_bad) begin
      err_sticky <= 1'b1;
    end
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_window_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_window_checker
// Brief    : Self-checking bench for sum_window_checker (WINDOW=4 and WINDOW=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_window_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // WINDOW=4 instance signals
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_sum = 9'd0;
  logic        in_bad = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_total;
  logic [8:0]  out_max;
  logic [3:0]  out_bad_cnt;
  logic [3:0]  out_count;
  logic        err_sticky;

  // WINDOW=1 instance signals
  logic        in_valid_w1 = 1'b0;
  logic        in_ready_w1;
  logic [8:0]  in_sum_w1 = 9'd0;
  logic        out_valid_w1;
  logic [12:0] out_total_w1;
  logic [8:0]  out_max_w1;
  logic [3:0]  out_bad_cnt_w1;
  logic [3:0]  out_count_w1;
  logic        err_sticky_w1;

  int total_n = 0;
  int bad_n   = 0;

`ifdef SUM_WINDOW_CHECKER_STICKY_EN
  localparam logic STICKY_EXP = 1'b1;
`else
  localparam logic STICKY_EXP = 1'b0;
`endif

  sum_window_checker #(.WINDOW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_bad(in_bad),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_max(out_max), .out_bad_cnt(out_bad_cnt),
    .out_count(out_count), .err_sticky(err_sticky)
  );

  sum_window_checker #(.WINDOW(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w1), .in_ready(in_ready_w1), .in_sum(in_sum_w1), .in_bad(1'b0),
    .flush(1'b0), .out_valid(out_valid_w1), .out_ready(1'b1),
    .out_total(out_total_w1), .out_max(out_max_w1), .out_bad_cnt(out_bad_cnt_w1),
    .out_count(out_count_w1), .err_sticky(err_sticky_w1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [8:0]  sum;
    logic        bad;
    logic        fl;
    logic        rep;
    logic [12:0] et;
    logic [8:0]  em;
    logic [3:0]  eb;
    logic [3:0]  ec;
  } vec_t;

  typedef struct {
    logic [12:0] t;
    logic [8:0]  m;
    logic [3:0]  b;
    logic [3:0]  c;
  } rep_t;

  rep_t exp_q[$];
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [8:0] s, input logic b, input logic f,
                              input logic r, input logic [12:0] et, input logic [8:0] em,
                              input logic [3:0] eb, input logic [3:0] ec);
    vec_t x;
    x.valid = v; x.sum = s; x.bad = b; x.fl = f; x.rep = r;
    x.et = et; x.em = em; x.eb = eb; x.ec = ec;
    return x;
  endfunction

  function automatic rep_t mkr(input logic [12:0] t, input logic [8:0] m,
                               input logic [3:0] b, input logic [3:0] c);
    rep_t r;
    r.t = t; r.m = m; r.b = b; r.c = c;
    return r;
  endfunction

  // Drive one vector on the next cycle the DUT is ready; push its report if one is due
  task automatic apply(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      in_valid = 1'b0;
      flush    = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total_n++;
      bad_n++;
      $display("FAIL ready_wait: got in_ready=0 for 20 cycles expected 1");
    end
    in_valid = v.valid;
    in_sum   = v.sum;
    in_bad   = v.bad;
    flush    = v.fl;
    if (v.rep) exp_q.push_back(mkr(v.et, v.em, v.eb, v.ec));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      in_bad   = 1'b0;
    end
  endtask

  // Scoreboard: pop and compare on every completed report handshake
  initial begin
    rep_t r;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_n++;
          bad_n++;
          $display("FAIL spurious_report: got report total=%0d count=%0d expected none",
                   out_total, out_count);
        end else begin
          r = exp_q.pop_front();
          chk("rep_total", out_total, r.t);
          chk("rep_max", out_max, r.m);
          chk("rep_bad_cnt", out_bad_cnt, r.b);
          chk("rep_count", out_count, r.c);
        end
      end
    end
  end

  initial begin
    int n1;
    tbl[0]  = mk(1, 224, 0, 0, 0,   0,   0, 0, 0);
    tbl[1]  = mk(1, 224, 0, 0, 0,   0,   0, 0, 0);
    tbl[2]  = mk(1, 224, 0, 0, 0,   0,   0, 0, 0);
    tbl[3]  = mk(1, 224, 0, 0, 1, 896, 224, 0, 4);
    tbl[4]  = mk(1, 511, 1, 0, 0,   0,   0, 0, 0);
    tbl[5]  = mk(1,   0, 1, 0, 0,   0,   0, 0, 0);
    tbl[6]  = mk(1, 100, 0, 0, 0,   0,   0, 0, 0);
    tbl[7]  = mk(1, 224, 0, 0, 1, 835, 511, 2, 4);
    tbl[8]  = mk(1,  10, 0, 0, 0,   0,   0, 0, 0);
    tbl[9]  = mk(1,  20, 0, 0, 0,   0,   0, 0, 0);
    tbl[10] = mk(1,  30, 0, 1, 1,  60,  30, 0, 3);
    tbl[11] = mk(0,   0, 0, 1, 0,   0,   0, 0, 0);  // flush on empty window
    tbl[12] = mk(0, 500, 1, 0, 0,   0,   0, 0, 0);  // not valid: ignored
    tbl[13] = mk(1,   5, 0, 0, 0,   0,   0, 0, 0);
    tbl[14] = mk(0,   0, 0, 1, 1,   5,   5, 0, 1);  // flush a partial window
    tbl[15] = mk(1, 300, 0, 1, 1, 300, 300, 0, 1);  // accept + flush from empty

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_total", out_total, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_w1_out_count", out_count_w1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table-driven windows with out_ready held high
    for (int i = 0; i < 4; i++) apply(tbl[i]);
    #1;
    chk("sticky_after_good", err_sticky, 0);
    for (int i = 4; i < 16; i++) apply(tbl[i]);
    idle(4);
    #1;
    chk("sticky_after_bad", err_sticky, STICKY_EXP);
    chk("queue_drained_1", exp_q.size(), 0);

    // Report held with out_ready low; latency, stability and back-pressure
    out_ready = 1'b0;
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 2, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 4, 0, 0, 1, 10, 4, 0, 4));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("latency_out_valid", out_valid, 1);
    chk("latency_in_ready", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sum = 9'd511; in_bad = 1'b1; flush = 1'b1;
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_total", out_total, 10);
      chk("hold_count", out_count, 4);
    end
    @(negedge clk);
    in_valid = 1'b0; in_bad = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("after_ack_in_ready", in_ready, 1);
    chk("after_ack_out_valid", out_valid, 0);
    chk("after_ack_keep_total", out_total, 10);
    for (int i = 0; i < 4; i++) apply(mk(1, 1, 0, 0, i == 3, 4, 1, 0, 4));
    idle(3);
    #1;
    chk("queue_drained_2", exp_q.size(), 0);

    // Reset in the middle of a window
    apply(mk(1, 50, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 60, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0; in_bad = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_total", out_total, 0);
    chk("midrst_max", out_max, 0);
    chk("midrst_bad_cnt", out_bad_cnt, 0);
    chk("midrst_count", out_count, 0);
    chk("midrst_sticky", err_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) apply(mk(1, 3, 0, 0, i == 3, 12, 3, 0, 4));
    idle(3);
    #1;
    chk("queue_drained_3", exp_q.size(), 0);

    // WINDOW=1 with continuous valid: one report every other cycle
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid_w1 = 1'b1;
      in_sum_w1   = 9'(c + 1);
      #1;
      chk("w1_out_valid", out_valid_w1, (c % 2) == 1);
      if (out_valid_w1) begin
        chk("w1_count", out_count_w1, 1);
        chk("w1_total", out_total_w1, c);
        n1++;
      end
    end
    @(negedge clk);
    in_valid_w1 = 1'b0;
    chk("w1_reports", n1, 5);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
`default_nettype wire
